// File: rtl/playbus_pkg.sv
// Shared types and phase decode for the PlayBus strobe arbiter.
package playbus_pkg;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        ROM_RD  = 3'd1,
        RAM_RD  = 3'd2,
        RAM_WR  = 3'd3,
        SW_RD   = 3'd4,
        LED_WR  = 3'd5,
        ROM_LED = 3'd6,
        SW_RAM  = 3'd7
    } func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        TURN = 2'd3
    } state_t;

    typedef struct packed {
        logic romo;
        logic ramo;
        logic ramw;
        logic swben;
        logic ledltch;
    } strobes_t;

    function automatic logic two_phase(input func_t f);
        return f inside {RAM_WR, SW_RD, LED_WR, ROM_LED, SW_RAM};
    endfunction

    // Strobes driven during one phase of a function; ph2 selects the second phase.
    function automatic strobes_t phase_strobes(input func_t f, input logic ph2);
        strobes_t s;
        s = '0;
        case (f)
            ROM_RD:  s.romo = 1'b1;
            RAM_RD:  s.ramo = 1'b1;
            RAM_WR:  s.ramw = ph2;
            SW_RD:   s.swben = 1'b1;
            LED_WR:  s.ledltch = ph2;
            ROM_LED: begin
                s.romo    = 1'b1;
                s.ledltch = ph2;
            end
            SW_RAM: begin
                s.swben = 1'b1;
                s.ramw  = ph2;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/playbus_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [NREQ-1:0] upper;

    always_comb begin
        upper = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            upper[i] = req[i] && (i >= int'(ptr));
        end
    end

    // Lowest set bit at/above ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) idx = IDXW'(i);
        end
        if (|upper) begin
            for (int i = int'(NREQ) - 1; i >= 0; i--) begin
                if (upper[i]) idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/playbus_arbiter.sv
// Round-robin sharer of the PlayBus control strobes between NREQ requesters.
// Optional bus locking for back-to-back transactions is built when PLAYBUS_LOCK_EN is defined.
module playbus_arbiter
    import playbus_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*3-1:0] func,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              ROMO,
    output logic              RAMO,
    output logic              RAMW,
    output logic              SWBEN,
    output logic              LEDLTCH,
    output logic              busy
`ifdef PLAYBUS_LOCK_EN
    ,
    input  logic [NREQ-1:0]   lock
`endif
);

    localparam int unsigned IDXW = (NREQ > 2) ? 2 : 1;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] cur;
    func_t           cur_func;
    logic [1:0]      turn_cnt;
    strobes_t        strb;

    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic [IDXW-1:0] next_ptr;
    func_t           pick_func;
    func_t           own_func;
    logic            last_phase;
    logic            lock_hit;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_comb begin
        pick_func = NOP;
        own_func  = NOP;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDXW'(i) == pick_idx) pick_func = func_t'(func[3*i +: 3]);
            if (IDXW'(i) == cur)      own_func  = func_t'(func[3*i +: 3]);
        end
    end

    assign next_ptr   = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + IDXW'(1);
    assign last_phase = (state == PH2) || ((state == PH1) && !two_phase(cur_func));

`ifdef PLAYBUS_LOCK_EN
    assign lock_hit = lock[cur] && req[cur];
`else
    assign lock_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cur      <= '0;
            cur_func <= NOP;
            turn_cnt <= '0;
            gnt      <= '0;
            done     <= '0;
            strb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= PH1;
                        cur      <= pick_idx;
                        cur_func <= pick_func;
                        ptr      <= next_ptr;
                        gnt      <= onehot(pick_idx);
                        strb     <= phase_strobes(pick_func, 1'b0);
                        done     <= two_phase(pick_func) ? '0 : onehot(pick_idx);
                    end
                end
                PH1, PH2: begin
                    if (!last_phase) begin
                        state <= PH2;
                        strb  <= phase_strobes(cur_func, 1'b1);
                        done  <= onehot(cur);
                    end else if (lock_hit) begin
                        // Locked owner keeps the bus: new function starts at once, pointer held.
                        state    <= PH1;
                        cur_func <= own_func;
                        strb     <= phase_strobes(own_func, 1'b0);
                        done     <= two_phase(own_func) ? '0 : onehot(cur);
                    end else begin
                        gnt  <= '0;
                        done <= '0;
                        strb <= '0;
                        if (TURNAROUND > 0) begin
                            state    <= TURN;
                            turn_cnt <= 2'(TURNAROUND - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                TURN: begin
                    if (turn_cnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign ROMO    = strb.romo;
    assign RAMO    = strb.ramo;
    assign RAMW    = strb.ramw;
    assign SWBEN   = strb.swben;
    assign LEDLTCH = strb.ledltch;

    assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    assert property (@(posedge clk) disable iff (reset) $onehot0({ROMO, RAMO, SWBEN}));
    assert property (@(posedge clk) disable iff (reset) ((done & ~gnt) == '0));

endmodule

// File: tb/tb_playbus_arbiter.sv
// Bench for playbus_arbiter: directed literal checks plus random traffic against a
// transaction-level model that schedules the expected per-cycle outputs in a queue.
module tb_playbus_arbiter;

    localparam int NREQ       = 2;
    localparam int TURNAROUND = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [2:0]        fv [NREQ];
    logic [NREQ*3-1:0] func;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              ROMO, RAMO, RAMW, SWBEN, LEDLTCH, busy;
    logic [NREQ-1:0]   lock;
    logic [4:0]        dut_strb;

    for (genvar g = 0; g < NREQ; g++) begin : g_func
        assign func[3*g +: 3] = fv[g];
    end
    assign dut_strb = {ROMO, RAMO, RAMW, SWBEN, LEDLTCH};

    playbus_arbiter #(
        .NREQ       (NREQ),
        .TURNAROUND (TURNAROUND)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .func    (func),
        .gnt     (gnt),
        .done    (done),
        .ROMO    (ROMO),
        .RAMO    (RAMO),
        .RAMW    (RAMW),
        .SWBEN   (SWBEN),
        .LEDLTCH (LEDLTCH),
        .busy    (busy)
`ifdef PLAYBUS_LOCK_EN
        ,
        .lock    (lock)
`endif
    );

    initial forever #5 clk = ~clk;

    // Strobe order {ROMO,RAMO,RAMW,SWBEN,LEDLTCH}, straight from the function decode list.
    logic [4:0] ph1_tab [8] = '{5'b00000, 5'b10000, 5'b01000, 5'b00000,
                                5'b00010, 5'b00000, 5'b10000, 5'b00010};
    logic [4:0] ph2_tab [8] = '{5'b00000, 5'b00000, 5'b00000, 5'b00100,
                                5'b00010, 5'b00001, 5'b10001, 5'b00110};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] done;
        logic [4:0]      strb;
        logic            busy;
    } rec_t;

    rec_t q[$];
    rec_t exp_cur = '0;
    int   mptr = 0;
    bit   model_ok = 1'b0;

    task automatic push_txn(input int w, input logic [2:0] f);
        rec_t r;
        bit   two;
        two = (f >= 3'd3);
        r = '0;
        r.gnt[w] = 1'b1;
        r.busy   = 1'b1;
        r.strb   = ph1_tab[f];
        if (!two) r.done[w] = 1'b1;
        q.push_back(r);
        if (two) begin
            r.strb    = ph2_tab[f];
            r.done[w] = 1'b1;
            q.push_back(r);
        end
        for (int k = 0; k < TURNAROUND; k++) begin
            r      = '0;
            r.busy = 1'b1;
            q.push_back(r);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            q.delete();
            mptr     = 0;
            exp_cur  = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (!exp_cur.busy && req != '0) begin
                int w;
                w = -1;
                for (int off = 0; off < NREQ; off++) begin
                    int c;
                    c = (mptr + off) % NREQ;
                    if (w < 0 && req[c]) w = c;
                end
                mptr = (w + 1) % NREQ;
                push_txn(w, fv[w]);
            end else if (exp_cur.done != '0) begin
`ifdef PLAYBUS_LOCK_EN
                int w;
                w = 0;
                for (int i = 0; i < NREQ; i++) if (exp_cur.done[i]) w = i;
                if (lock[w] && req[w]) begin
                    q.delete();
                    push_txn(w, fv[w]);
                end
`endif
            end
            if (q.size() > 0) exp_cur = q.pop_front();
            else exp_cur = '0;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("m_gnt", 32'(gnt), 32'(exp_cur.gnt));
            chk("m_done", 32'(done), 32'(exp_cur.done));
            chk("m_strb", 32'(dut_strb), 32'(exp_cur.strb));
            chk("m_busy", 32'(busy), 32'(exp_cur.busy));
            chk("m_mutex", 32'($countones({ROMO, RAMO, SWBEN}) <= 1), 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus and literal checks ----------------
    initial begin
        int order[$];
        reset = 1'b1;
        req   = '1;
        lock  = '0;
        for (int i = 0; i < NREQ; i++) fv[i] = 3'd0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_strb", 32'(dut_strb), 32'd0);
        end

        // Single-phase ROM read
        reset = 1'b0;
        req   = 2'b01;
        fv[0] = 3'd1;
        @(negedge clk);
        chk("sp_gnt", 32'(gnt), 32'h1);
        chk("sp_strb", 32'(dut_strb), 32'b10000);
        chk("sp_done", 32'(done), 32'h1);
        req = '0;
        @(negedge clk);
        chk("sp_turn_strb", 32'(dut_strb), 32'd0);
        chk("sp_turn_gnt", 32'(gnt), 32'd0);
        chk("sp_turn_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sp_idle_busy", 32'(busy), 32'd0);

        // Two-phase codes on requester 1
        for (int f = 3; f <= 7; f++) begin
            req   = 2'b10;
            fv[1] = 3'(f);
            @(negedge clk);
            chk("tp_ph1_gnt", 32'(gnt), 32'h2);
            chk("tp_ph1_strb", 32'(dut_strb), 32'(ph1_tab[f]));
            chk("tp_ph1_done", 32'(done), 32'd0);
            chk("tp_ph1_ramw", 32'(RAMW), 32'd0);
            if (f == 3) req = '0;
            @(negedge clk);
            chk("tp_ph2_gnt", 32'(gnt), 32'h2);
            chk("tp_ph2_strb", 32'(dut_strb), 32'(ph2_tab[f]));
            chk("tp_ph2_done", 32'(done), 32'h2);
            req = '0;
            repeat (TURNAROUND + 1) @(negedge clk);
        end

        // Fairness with both requesters held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 2'b11;
        fv[0] = 3'd2;
        fv[1] = 3'd2;
        for (int c = 0; c < 30 && order.size() < 4; c++) begin
            @(negedge clk);
            if (done[0]) order.push_back(0);
            else if (done[1]) order.push_back(1);
        end
        req = '0;
        chk("fair_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size(); k++) chk("fair_order", 32'(order[k]), 32'(k % 2));
        repeat (3) @(negedge clk);

        // Reset during PH2 of SW->RAM
        req   = 2'b10;
        fv[1] = 3'd7;
        @(negedge clk);
        chk("rm_ph1_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        chk("rm_ph2_strb", 32'(dut_strb), 32'b00110);
        reset = 1'b1;
        req   = 2'b11;
        fv[0] = 3'd2;
        @(negedge clk);
        chk("rm_gnt", 32'(gnt), 32'd0);
        chk("rm_done", 32'(done), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_strb", 32'(dut_strb), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rm_winner", 32'(gnt), 32'h1);
        req = '0;
        repeat (3) @(negedge clk);

`ifdef PLAYBUS_LOCK_EN
        // Locked back-to-back LED write then RAM write
        lock  = 2'b01;
        req   = 2'b01;
        fv[0] = 3'd5;
        @(negedge clk);
        chk("lk_ph1_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("lk_ph2_strb", 32'(dut_strb), 32'b00001);
        chk("lk_ph2_done", 32'(done), 32'h1);
        fv[0] = 3'd3;
        @(negedge clk);
        chk("lk_b2b_gnt", 32'(gnt), 32'h1);
        chk("lk_b2b_busy", 32'(busy), 32'd1);
        chk("lk_b2b_strb", 32'(dut_strb), 32'd0);
        lock = '0;
        @(negedge clk);
        chk("lk2_strb", 32'(dut_strb), 32'b00100);
        chk("lk2_done", 32'(done), 32'h1);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && done[i]) begin
                    if ($urandom_range(0, 1) == 1) fv[i] = 3'($urandom_range(0, 7));
                    else req[i] = 1'b0;
                end else if (req[i] && gnt[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                    else if ($urandom_range(0, 3) == 0) fv[i] = 3'($urandom_range(0, 7));
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        fv[i]  = 3'($urandom_range(0, 7));
                    end
                end
            end
            lock = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        end
        reset = 1'b0;
        req   = '0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
